cmap_ctrl: RTL and testbench

CMAP_CTRL -- requirements
Module: cmap_ctrl

---
 rtl/cmap_pkg.sv | 25 ++
 rtl/cmap_ram.sv | 43 ++++
 rtl/cmap_ctrl.sv | 147 ++++++++++++++
 tb/tb_cmap_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cmap_pkg : shared defaults, FSM states and grey-ramp helper   |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
package cmap_pkg;

  localparam int CMAP_PW_DEF = 8;
  localparam int CMAP_CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } cmap_state_e;

  // Grey level for table index idx: zero-extended, or truncated to the low cw bits.
  function automatic logic [31:0] cmap_grey(input logic [31:0] idx, input int unsigned cw);
    logic [31:0] mask;
    mask = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    return idx & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmap_ram.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cmap_ram : two-bank colour table, 1 sync write + 1 sync read  |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module cmap_ram #(
  parameter int AW = 8,
  parameter int DW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic          i_we_both,
  input  logic [AW:0]   i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW:0]   i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**(AW+1)];

  // Broadcast writes hit the same index in both banks within one cycle.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
      if (i_we_both) begin
        r_mem[{~i_waddr[AW], i_waddr[AW-1:0]}] <= i_wdata;
      end
    end
  end

  // Only the read register is reset; the array itself is rewritten by INIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cmap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------+
// | cmap_ctrl : double-buffered colour-map lookup on a pixel stream |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module cmap_ctrl
  import cmap_pkg::*;
#(
  parameter int PW = CMAP_PW_DEF,
  parameter int CW = CMAP_CW_DEF
) (
  input  logic            i_clk,
  input  logic            i_areset_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [PW-1:0]   s_pixel,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [CW-1:0]   m_r,
  output logic [CW-1:0]   m_g,
  output logic [CW-1:0]   m_b,
  output logic            m_last,
  input  logic            i_cfg_we,
  input  logic [PW-1:0]   i_cfg_addr,
  input  logic [3*CW-1:0] i_cfg_data,
  input  logic            i_cfg_swap,
  output logic            o_cfg_ready,
  output logic            o_active_bank
);

  localparam int            c_dw       = 3 * CW;
  localparam logic [PW-1:0] c_last_idx = '1;

  cmap_state_e      r_state, w_state_nxt;
  logic [PW-1:0]    r_init_addr;
  logic             r_bank;
  logic             r_s1_valid, r_s1_last, r_s1_bank;
  logic [PW-1:0]    r_s1_pixel;
  logic             r_m_valid, r_m_last, r_s2_bank;
  logic             w_en, w_accept, w_shadow_busy, w_swap_done;
  logic             w_we, w_we_both;
  logic [PW:0]      w_waddr;
  logic [c_dw-1:0]  w_wdata, w_rdata;
  logic [CW-1:0]    w_grey;

  assign w_en        = !r_m_valid || m_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_swap_done = (r_state == ST_PEND) && w_accept && s_last;
  assign w_grey      = CW'(cmap_grey(32'(r_init_addr), CW));

  // The shadow bank may not be touched while a beat tagged with it is still in flight.
  assign w_shadow_busy = (r_s1_valid && (r_s1_bank != r_bank)) ||
                         (r_m_valid  && (r_s2_bank != r_bank));

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_addr == c_last_idx)     w_state_nxt = ST_RUN;
      ST_RUN:  if (i_cfg_swap && o_cfg_ready)     w_state_nxt = ST_PEND;
      ST_PEND: if (w_accept && s_last)            w_state_nxt = ST_RUN;
      default:                                    w_state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    s_ready     = 1'b0;
    o_cfg_ready = 1'b0;
    w_we        = 1'b0;
    w_we_both   = 1'b0;
    w_waddr     = {~r_bank, i_cfg_addr};
    w_wdata     = i_cfg_data;
    if (r_state == ST_INIT) begin
      w_we      = 1'b1;
      w_we_both = 1'b1;
      w_waddr   = {1'b0, r_init_addr};
      w_wdata   = {w_grey, w_grey, w_grey};
    end else begin
      s_ready     = w_en;
      o_cfg_ready = (r_state == ST_RUN) && !w_shadow_busy;
      w_we        = i_cfg_we && o_cfg_ready;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_init_addr <= '0;
      r_bank      <= 1'b0;
    end else begin
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
      if (w_swap_done)        r_bank      <= ~r_bank;
    end
  end

  // Two-stage pipe: stage 1 holds the accepted beat, stage 2 is the table read.
  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_pixel <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_s2_bank  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_s1_last  <= s_last;
      r_s1_bank  <= r_bank;
      r_s1_pixel <= s_pixel;
      r_m_valid  <= r_s1_valid;
      r_m_last   <= r_s1_last;
      r_s2_bank  <= r_s1_bank;
    end
  end

  cmap_ram #(
    .AW (PW),
    .DW (c_dw)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst_n   (i_areset_n),
    .i_we      (w_we),
    .i_we_both (w_we_both),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_re      (w_en),
    .i_raddr   ({r_s1_bank, r_s1_pixel}),
    .o_rdata   (w_rdata)
  );

  assign m_valid       = r_m_valid;
  assign m_last        = r_m_last;
  assign m_r           = w_rdata[3*CW-1:2*CW];
  assign m_g           = w_rdata[2*CW-1:CW];
  assign m_b           = w_rdata[CW-1:0];
  assign o_active_bank = r_bank;

endmodule
`default_nettype wire

// File: tb/tb_cmap_ctrl.sv
`default_nettype none
// Self-checking bench for cmap_ctrl: vector table, directed corner sequences,
// then random traffic scored against a bank-table model.
module tb_cmap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        s_valid = 1'b0, s_ready, s_last = 1'b0;
  logic [7:0]  s_pixel = '0;
  logic        m_valid, m_ready = 1'b1, m_last;
  logic [7:0]  m_r, m_g, m_b;
  logic        i_cfg_we = 1'b0, i_cfg_swap = 1'b0, o_cfg_ready, o_active_bank;
  logic [7:0]  i_cfg_addr = '0;
  logic [23:0] i_cfg_data = '0;

  cmap_ctrl #(.PW(8), .CW(8)) dut (
    .i_clk(i_clk), .i_areset_n(i_areset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_g(m_g), .m_b(m_b), .m_last(m_last),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
    .i_cfg_swap(i_cfg_swap), .o_cfg_ready(o_cfg_ready), .o_active_bank(o_active_bank)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [23:0] rgb;
    logic        last;
    logic        tag;
  } exp_t;

  exp_t        q[$];
  logic [23:0] tbl [2][256];
  logic        act_bank = 1'b0;
  logic        pend = 1'b0;
  int          init_cnt = 0;
  logic [23:0] last_rgb = '0;

  always @(negedge i_clk) begin
    if (!i_areset_n) begin
      q.delete();
      act_bank = 1'b0;
      pend     = 1'b0;
      init_cnt = 0;
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 256; i++) tbl[b][i] = {3{i[7:0]}};
      chk("rst_m_valid", m_valid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_cfg_ready", o_cfg_ready, 0);
      chk("rst_bank", o_active_bank, 0);
    end else begin
      bit run, ready, busy;
      run  = (init_cnt >= 256);
      busy = 1'b0;
      foreach (q[k]) if (q[k].tag != act_bank) busy = 1'b1;
      ready = run && !pend && !busy;
      chk("cfg_ready", o_cfg_ready, ready);
      chk("active_bank", o_active_bank, act_bank);
      if (!run) chk("s_ready_init", s_ready, 0);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat_rgb", {m_r, m_g, m_b}, e.rgb);
          chk("beat_last", m_last, e.last);
          last_rgb = {m_r, m_g, m_b};
        end
      end
      if (s_valid && s_ready) q.push_back('{tbl[act_bank][s_pixel], s_last, act_bank});
      if (i_cfg_we && ready) tbl[act_bank ^ 1'b1][i_cfg_addr] = i_cfg_data;
      if (i_cfg_swap && ready) pend = 1'b1;
      else if (pend && s_valid && s_ready && s_last) begin
        pend     = 1'b0;
        act_bank = act_bank ^ 1'b1;
      end
      if (init_cnt < 256) init_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] pix, input logic last, input logic sw);
    bit ok = 0;
    s_valid = 1'b1; s_pixel = pix; s_last = last; i_cfg_swap = sw;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge i_clk);
      ok = s_ready;
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0; i_cfg_swap = 1'b0;
    chk("send_timeout", ok, 1);
  endtask

  task automatic cfg(input logic we, input logic [7:0] a, input logic [23:0] d, input logic sw);
    bit ok = 0;
    i_cfg_we = we; i_cfg_addr = a; i_cfg_data = d; i_cfg_swap = sw;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge i_clk);
      ok = o_cfg_ready;
      tick();
    end
    i_cfg_we = 1'b0; i_cfg_swap = 1'b0;
    chk("cfg_timeout", ok, 1);
  endtask

  task automatic drain();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    chk("drain_empty", q.size(), 0);
  endtask

  typedef struct packed {
    logic [7:0]  pix;
    logic        last;
    logic [23:0] rgb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [32:0] snap;
    int          pix;

    vecs[0] = '{8'h00, 1'b0, 24'h000000};
    vecs[1] = '{8'h80, 1'b0, 24'h808080};
    vecs[2] = '{8'hFF, 1'b0, 24'hFFFFFF};
    vecs[3] = '{8'h01, 1'b0, 24'h010101};
    vecs[4] = '{8'h7F, 1'b0, 24'h7F7F7F};
    vecs[5] = '{8'h10, 1'b1, 24'h101010};

    repeat (3) tick();
    i_areset_n = 1'b1;
    repeat (256) tick();

    // Grey ramp after INIT, fixed two-cycle latency, back-to-back beats.
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        s_valid = 1'b1; s_pixel = vecs[k].pix; s_last = vecs[k].last;
      end else begin
        s_valid = 1'b0; s_last = 1'b0;
      end
      @(negedge i_clk);
      if (k < 6) chk("vec_s_ready", s_ready, 1);
      if (k >= 2) begin
        chk("vec_m_valid", m_valid, 1);
        chk("vec_rgb", {m_r, m_g, m_b}, vecs[k-2].rgb);
        chk("vec_last", m_last, vecs[k-2].last);
      end else begin
        chk("vec_m_idle", m_valid, 0);
      end
      tick();
    end

    // Shadow write + swap completes only at the frame's s_last.
    cfg(1'b1, 8'h10, 24'hFF0000, 1'b0);
    cfg(1'b0, 8'h00, 24'h0, 1'b1);
    send(8'h10, 1'b0, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    send(8'h30, 1'b0, 1'b0);
    send(8'h40, 1'b1, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    drain();
    chk("swap_new_colour", last_rgb, 24'hFF0000);
    @(negedge i_clk);
    chk("swap_bank", o_active_bank, 1);
    tick();

    // Back-pressure: five stalled cycles mid-stream.
    pix = 0;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      s_valid = 1'b1; s_pixel = pix[7:0]; s_last = 1'b0;
      m_ready = !(c >= 6 && c < 11);
      @(negedge i_clk);
      if (c == 6) begin
        snap = {m_valid, m_r, m_g, m_b, m_last};
        chk("stall_m_valid", m_valid, 1);
      end
      if (c > 6 && c < 11) chk("stall_stable", 32'(snap), 32'({m_valid, m_r, m_g, m_b, m_last}));
      if (c >= 6 && c < 11) chk("stall_s_ready", s_ready, 0);
      acc = s_valid && s_ready;
      tick();
      if (acc) pix++;
    end
    drain();

    // Writes while PEND are dropped.
    cfg(1'b0, 8'h00, 24'h0, 1'b1);
    i_cfg_we = 1'b1; i_cfg_addr = 8'h20; i_cfg_data = 24'hFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("pend_cfg_ready", o_cfg_ready, 0);
      tick();
    end
    i_cfg_we = 1'b0;
    send(8'h00, 1'b1, 1'b0);
    send(8'h20, 1'b0, 1'b0);
    drain();
    chk("pend_write_ignored", last_rgb, 24'h202020);
    @(negedge i_clk);
    chk("pend_bank", o_active_bank, 0);
    chk("idle_cfg_ready", o_cfg_ready, 1);
    tick();

    // Swap coinciding with an s_last acceptance waits for the next frame.
    send(8'h05, 1'b1, 1'b1);
    send(8'h06, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("coinc_bank_held", o_active_bank, 0);
    tick();
    send(8'h08, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("coinc_bank_toggled", o_active_bank, 1);
    tick();
    drain();

    // Async reset during PEND with two beats in flight.
    cfg(1'b0, 8'h00, 24'h0, 1'b1);
    m_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    #2 i_areset_n = 1'b0;
    #1;
    chk("areset_m_valid", m_valid, 0);
    chk("areset_s_ready", s_ready, 0);
    chk("areset_cfg_ready", o_cfg_ready, 0);
    chk("areset_bank", o_active_bank, 0);
    tick();
    tick();
    i_areset_n = 1'b1;
    m_ready = 1'b1;
    repeat (256) tick();
    @(negedge i_clk);
    chk("reinit_s_ready", s_ready, 1);
    tick();
    cfg(1'b0, 8'h00, 24'h0, 1'b1);
    send(8'h00, 1'b1, 1'b0);
    send(8'h10, 1'b0, 1'b0);
    drain();
    chk("reinit_bank1_grey", last_rgb, 24'h101010);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      s_valid    = ($urandom_range(0, 9) < 7);
      s_pixel    = 8'($urandom);
      s_last     = ($urandom_range(0, 7) == 0);
      m_ready    = ($urandom_range(0, 9) < 7);
      i_cfg_we   = ($urandom_range(0, 2) == 0);
      i_cfg_addr = 8'($urandom);
      i_cfg_data = 24'($urandom);
      i_cfg_swap = ($urandom_range(0, 9) == 0);
      tick();
    end
    s_last = 1'b0; i_cfg_we = 1'b0; i_cfg_swap = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
